// File: rtl/id_ex_operand_reg_if.sv
// ID/EX operand register bundle: decoded ID fields and forwarding sources in,
// registered EX-stage fields, load-use stall and bubble counter out.
interface id_ex_operand_reg_if #(
  parameter int DW = 64,
  parameter int CW = 16
);
  // ID stage instruction
  logic          id_valid;
  logic [4:0]    id_rn;
  logic [4:0]    id_rm;
  logic          id_uses_rm;
  logic [4:0]    id_rd;
  logic [DW-1:0] id_rdata1;
  logic [DW-1:0] id_rdata2;
  logic [DW-1:0] id_imm;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_alu_src;
  logic          id_mem_to_reg;
  logic [2:0]    id_alu_op;
  // Forwarding sources from EX and MEM
  logic          fwd_ex_reg_write;
  logic          fwd_ex_mem_read;
  logic [4:0]    fwd_ex_rd;
  logic [DW-1:0] fwd_ex_result;
  logic          fwd_mem_reg_write;
  logic [4:0]    fwd_mem_rd;
  logic [DW-1:0] fwd_mem_result;
  logic          flush;
  // Hazard and EX stage outputs
  logic          stall;
  logic          out_valid;
  logic [4:0]    out_rn;
  logic [4:0]    out_rm;
  logic [4:0]    out_rd;
  logic [DW-1:0] out_opA;
  logic [DW-1:0] out_opB;
  logic [DW-1:0] out_imm;
  logic          out_reg_write;
  logic          out_mem_read;
  logic          out_mem_write;
  logic          out_alu_src;
  logic          out_mem_to_reg;
  logic [2:0]    out_alu_op;
  logic [CW-1:0] bubble_count;

  modport master (
    output id_valid, id_rn, id_rm, id_uses_rm, id_rd, id_rdata1, id_rdata2, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_mem_to_reg, id_alu_op,
           fwd_ex_reg_write, fwd_ex_mem_read, fwd_ex_rd, fwd_ex_result,
           fwd_mem_reg_write, fwd_mem_rd, fwd_mem_result, flush,
    input  stall, out_valid, out_rn, out_rm, out_rd, out_opA, out_opB, out_imm,
           out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_mem_to_reg,
           out_alu_op, bubble_count
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_uses_rm, id_rd, id_rdata1, id_rdata2, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_mem_to_reg, id_alu_op,
           fwd_ex_reg_write, fwd_ex_mem_read, fwd_ex_rd, fwd_ex_result,
           fwd_mem_reg_write, fwd_mem_rd, fwd_mem_result, flush,
    output stall, out_valid, out_rn, out_rm, out_rd, out_opA, out_opB, out_imm,
           out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_mem_to_reg,
           out_alu_op, bubble_count
  );
endinterface

// File: rtl/id_ex_operand_reg.sv
// ID/EX pipeline register with EX/MEM operand forwarding, load-use hazard
// detection (one-cycle bubble) and a saturating bubble counter.
module id_ex_operand_reg #(
  parameter int DW = 64,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                reset,   // synchronous, active-low
  id_ex_operand_reg_if.slave  bus
);

  // X31 reads as zero, so it can never carry a forwarded or hazarding value.
  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic          valid;
    logic [4:0]    rn;
    logic [4:0]    rm;
    logic [4:0]    rd;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] imm;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          alu_src;
    logic          mem_to_reg;
    logic [2:0]    alu_op;
  } ex_entry_t;

  ex_entry_t     entry_d, entry_q;
  logic [CW-1:0] bubble_count_d, bubble_count_q;

  logic          rn_live, rm_live;
  logic          ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic          stall;
  logic [DW-1:0] op_a, op_b;

  // Source matching, load-use detection and forwarded operand selection.
  always_comb begin
    rn_live   = bus.id_valid && (bus.id_rn != XZR);
    rm_live   = bus.id_valid && bus.id_uses_rm && (bus.id_rm != XZR);
    ex_hit_a  = rn_live && bus.fwd_ex_reg_write  && (bus.fwd_ex_rd  == bus.id_rn);
    ex_hit_b  = rm_live && bus.fwd_ex_reg_write  && (bus.fwd_ex_rd  == bus.id_rm);
    mem_hit_a = rn_live && bus.fwd_mem_reg_write && (bus.fwd_mem_rd == bus.id_rn);
    mem_hit_b = rm_live && bus.fwd_mem_reg_write && (bus.fwd_mem_rd == bus.id_rm);
    // A load in EX has no result yet; a match against it must wait a cycle.
    stall     = bus.fwd_ex_mem_read && (ex_hit_a || ex_hit_b);

    if (ex_hit_a && !bus.fwd_ex_mem_read) op_a = bus.fwd_ex_result;
    else if (mem_hit_a)                   op_a = bus.fwd_mem_result;
    else                                  op_a = bus.id_rdata1;

    if (ex_hit_b && !bus.fwd_ex_mem_read) op_b = bus.fwd_ex_result;
    else if (mem_hit_b)                   op_b = bus.fwd_mem_result;
    else                                  op_b = bus.id_rdata2;
  end

  // Next EX entry: flush beats stall beats capture; bubbles are all-zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    entry_d        = '0;
    bubble_count_d = bubble_count_q;
    if (bus.flush) begin
      entry_d = '0;
    end else if (stall) begin
      if (bubble_count_q != '1) bubble_count_d = bubble_count_q + CW'(1);
    end else begin
      entry_d.valid      = bus.id_valid;
      entry_d.rn         = bus.id_rn;
      entry_d.rm         = bus.id_rm;
      entry_d.rd         = bus.id_rd;
      entry_d.op_a       = op_a;
      entry_d.op_b       = op_b;
      entry_d.imm        = bus.id_imm;
      // An invalid slot must not carry live control into EX.
      entry_d.reg_write  = bus.id_valid && bus.id_reg_write;
      entry_d.mem_read   = bus.id_valid && bus.id_mem_read;
      entry_d.mem_write  = bus.id_valid && bus.id_mem_write;
      entry_d.alu_src    = bus.id_valid && bus.id_alu_src;
      entry_d.mem_to_reg = bus.id_valid && bus.id_mem_to_reg;
      entry_d.alu_op     = bus.id_valid ? bus.id_alu_op : 3'd0;
    end
  end

  // Pipeline register and counter, synchronously cleared.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      entry_q        <= '0;
      bubble_count_q <= '0;
    end else begin
      entry_q        <= entry_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.stall          = stall;
  assign bus.out_valid      = entry_q.valid;
  assign bus.out_rn         = entry_q.rn;
  assign bus.out_rm         = entry_q.rm;
  assign bus.out_rd         = entry_q.rd;
  assign bus.out_opA        = entry_q.op_a;
  assign bus.out_opB        = entry_q.op_b;
  assign bus.out_imm        = entry_q.imm;
  assign bus.out_reg_write  = entry_q.reg_write;
  assign bus.out_mem_read   = entry_q.mem_read;
  assign bus.out_mem_write  = entry_q.mem_write;
  assign bus.out_alu_src    = entry_q.alu_src;
  assign bus.out_mem_to_reg = entry_q.mem_to_reg;
  assign bus.out_alu_op     = entry_q.alu_op;
  assign bus.bubble_count   = bubble_count_q;

endmodule

// File: doc/id_ex_operand_reg.md
Name: id_ex_operand_reg

Overview:
- ID/EX pipeline register, directly downstream of the register file's read ports.
- Captures ReadData1/ReadData2 plus decoded control, and applies EX/MEM forwarding before latching.
- Detects load-use hazards and inserts bubbles; honours branch flush.
- Feeds the EX stage ALU and operand muxes.

Parameters:
- DW, 64, datapath width (register and immediate width)
- CW, 16, width of the bubble performance counter

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clk
- id_valid  in  1  ID stage holds a real instruction
- id_rn  in  5  first source register (drives regfile ReadRegister1)
- id_rm  in  5  second source register (drives regfile ReadRegister2)
- id_uses_rm  in  1  instruction actually reads id_rm (R-type, store)
- id_rd  in  5  destination register
- id_rdata1  in  DW  regfile ReadData1
- id_rdata2  in  DW  regfile ReadData2
- id_imm  in  DW  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_mem_to_reg  in  1 each  decoded control
- id_alu_op  in  3  ALU opcode
- fwd_ex_reg_write  in  1  instruction now in EX will write a register
- fwd_ex_mem_read  in  1  instruction now in EX is a load
- fwd_ex_rd  in  5  its destination
- fwd_ex_result  in  DW  its ALU result (current cycle)
- fwd_mem_reg_write  in  1  instruction now in MEM will write a register
- fwd_mem_rd  in  5  its destination
- fwd_mem_result  in  DW  its final writeback value
- flush  in  1  squash the instruction entering EX (taken branch)
- stall  out  1  combinational; holds PC and IF/ID when high
- out_valid  out  1  registered; EX stage instruction is real
- out_rn, out_rm, out_rd  out  5 each  registered register numbers
- out_opA, out_opB  out  DW each  registered forwarded operands
- out_imm  out  DW  registered immediate
- out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_mem_to_reg  out  1 each  registered control
- out_alu_op  out  3  registered ALU opcode
- bubble_count  out  CW  saturating count of hazard bubbles inserted

Behaviour:
- Reset (reset==0 at posedge): all out_* and bubble_count go to 0. Reset overrides every other input.
- Register 31 is XZR: it is never a forwarding match and never triggers a hazard.
- Match condition for source s: valid source and s!=31 and writer reg_write and writer_rd==s.
  - Source rn is valid when id_valid.
  - Source rm is valid when id_valid and id_uses_rm.
- Hazard (stall): id_valid and fwd_ex_mem_read and fwd_ex_reg_write and fwd_ex_rd!=31, and fwd_ex_rd matches a valid source.
  - stall is purely combinational from current inputs; it is never registered.
- Operand A selection, in priority order:
  1. EX match (non-load) -> fwd_ex_result
  2. else MEM match -> fwd_mem_result
  3. else id_rdata1
- Operand B is selected the same way from id_rm/id_rdata2. Same-cycle WB writes are covered by the regfile's negedge write.
- Per-posedge action, in priority order:
  1. reset: as above.
  2. flush: bubble, counter unchanged.
  3. stall: bubble, bubble_count += 1, saturating at 2^CW-1.
  4. else capture all id_* fields and forwarded operands; out_valid = id_valid.
- Bubble: out_valid and all five 1-bit controls = 0, out_alu_op = 0. Data and register fields are don't-care but driven to 0.
- Latency: exactly one cycle from ID inputs to out_*.
- flush and stall together: the flush wins and no count is taken. stall still drives high combinationally that cycle.
- A stall lasts one cycle per load-use pair. The next cycle the load is in MEM, and the MEM path forwards its fwd_mem_result.
- id_valid==0: no hazard and no forwarding; captures an invalid, zero-control entry.

Test Plan:
- Reset low for 2 cycles with random inputs -> all out_* 0, bubble_count 0, stall 0. Release with id_rn=3, id_rdata1=0x11 -> out_opA=0x11 next cycle.
- id_rn=5, fwd_ex_reg_write=1, fwd_ex_rd=5, fwd_ex_result=0xAA, fwd_mem_reg_write=1, fwd_mem_rd=5, fwd_mem_result=0xBB -> out_opA=0xAA (EX priority). Drop the EX match -> 0xBB.
- id_rm=31, id_uses_rm=1, fwd_ex_rd=31, fwd_ex_reg_write=1, fwd_ex_result=0xFF, id_rdata2=0 -> out_opB=0, stall=0.
- Load in EX (fwd_ex_mem_read=1, fwd_ex_rd=7) with id_rm=7, id_uses_rm=1 -> stall=1, next out_valid=0, bubble_count=1.
  - Repeat with id_uses_rm=0 -> stall=0 and normal capture.
- Same hazard with flush=1 -> stall=1, out_valid=0, bubble_count unchanged. A normal instruction plus flush=1 -> bubble.
- Force bubble_count to 0xFFFF via repeated hazards (CW=16) -> one more hazard leaves 0xFFFF. Assert reset mid-stall -> 0.
